// File: rtl/fifo_sync_pkg.sv
// Shared definitions for the synchronous FIFO controller.
// Optional FWFT read mode is selected with FIFO_SYNC_FWFT_EN.
package fifo_sync_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_DEPTH = 16;
    localparam int AW        = ptr_width(DEF_DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int ERR_W   = 2;

endpackage

// File: rtl/fifo_sync_ram.sv
// Dual-port storage: synchronous write, asynchronous read.
// Contents are never reset.
module fifo_sync_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller with occupancy, almost and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads.
module fifo_sync_ctrl
    import fifo_sync_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     writeN,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     readN,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ptr_width(DEPTH):0] count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = ptr_width(DEPTH);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_MARGIN);

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [ADDR_W:0]    cnt;
    logic               empty_w, full_w;
    logic               wr_acc, rd_acc;
    logic [WIDTH-1:0]   rdata;

    // Wrap bit distinguishes full from empty when low bits match
    assign cnt     = wr_ptr_q - rd_ptr_q;
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0])
                   && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign wr_acc  = ~writeN & ~full_w;
    assign rd_acc  = ~readN & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (~writeN && full_w) begin
            err_d[ERR_OVF] = 1'b1;
        end
        if (~readN && empty_w) begin
            err_d[ERR_UDF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rdata)
    );

`ifdef FIFO_SYNC_FWFT_EN
    assign data_out   = rdata;
    assign data_valid = ~empty_w;
`else
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;

    always_comb begin
        dout_d = dout_q;
        dv_d   = rd_acc;
        if (rd_acc) begin
            dout_d = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
`endif

    assign count        = cnt;
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_full  = (cnt >= AF_LVL);
    assign almost_empty = (cnt <= AE_LVL);
    assign overflow     = err_q[ERR_OVF];
    assign underflow    = err_q[ERR_UDF];

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl (DEPTH=16 and DEPTH=8 instances).
// Works in both the default and FIFO_SYNC_FWFT_EN builds.
module tb_fifo_sync_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    bit mon_en  = 1'b0;

    // instance A: DEPTH=16
    logic       rst_a, wn_a, rn_a;
    logic [7:0] din_a, dout_a;
    logic       dv_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [4:0] cnt_a;

    // instance B: DEPTH=8
    logic       rst_b, wn_b, rn_b;
    logic [7:0] din_b, dout_b;
    logic       dv_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [3:0] cnt_b;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         recv_b = 0;

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2)) u_a (
        .clk(clk), .rst(rst_a), .writeN(wn_a), .data_in(din_a), .readN(rn_a),
        .data_out(dout_a), .data_valid(dv_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(8), .AF_MARGIN(2), .AE_MARGIN(2)) u_b (
        .clk(clk), .rst(rst_b), .writeN(wn_b), .data_in(din_b), .readN(rn_b),
        .data_out(dout_b), .data_valid(dv_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitors: a word counts as delivered when the DUT presents it
    always @(negedge clk) begin
        if (mon_en) begin
            logic take_a, take_b;
`ifdef FIFO_SYNC_FWFT_EN
            take_a = dv_a && !rn_a;
            take_b = dv_b && !rn_b;
`else
            take_a = dv_a;
            take_b = dv_b;
`endif
            if (take_a) begin
                if (q_a.size() == 0) begin
                    check("unexpected_a", {24'd0, dout_a}, 32'hFFFF_FFFF);
                end else begin
                    check("rd_data_a", {24'd0, dout_a}, {24'd0, q_a.pop_front()});
                end
            end
            if (take_b) begin
                recv_b++;
                if (q_b.size() == 0) begin
                    check("unexpected_b", {24'd0, dout_b}, 32'hFFFF_FFFF);
                end else begin
                    check("rd_data_b", {24'd0, dout_b}, {24'd0, q_b.pop_front()});
                end
            end
        end
    end

    task automatic reset_a();
        rst_a = 1'b1; wn_a = 1'b1; rn_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    initial begin
        int cyc;
        int sent;
        int mcnt;
        bit do_w, do_r;

        rst_a = 1'b1; wn_a = 1'b0; rn_a = 1'b0; din_a = 8'h77;
        rst_b = 1'b1; wn_b = 1'b1; rn_b = 1'b1; din_b = 8'h00;
        tick();
        tick();
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_dv", 32'(dv_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_udf", 32'(udf_a), 32'd0);
        check("rst_ae", 32'(ae_a), 32'd1);
        check("rst_af", 32'(af_a), 32'd0);
        rst_a = 1'b0; wn_a = 1'b1; rn_a = 1'b1;
        rst_b = 1'b0;
        mon_en = 1'b1;

        // fill to full, then one write too many
        for (int i = 0; i < 16; i++) begin
            din_a = 8'(i); wn_a = 1'b0;
            q_a.push_back(8'(i));
            tick();
            check("fill_count", 32'(cnt_a), 32'(i + 1));
            check("fill_af", 32'(af_a), 32'(i + 1 >= 14));
        end
        check("fill_full", 32'(full_a), 32'd1);
        check("fill_ovf0", 32'(ovf_a), 32'd0);
        din_a = 8'hAA;
        tick();
        wn_a = 1'b1;
        check("ovf_set", 32'(ovf_a), 32'd1);
        check("ovf_count", 32'(cnt_a), 32'd16);

        // drain and read past empty
        rn_a = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("drain_count", 32'(cnt_a), 32'(16 - k));
            check("drain_ae", 32'(ae_a), 32'(16 - k <= 2));
        end
        tick();
        rn_a = 1'b1;
        check("udf_set", 32'(udf_a), 32'd1);
        check("udf_dv", 32'(dv_a), 32'd0);
        check("udf_count", 32'(cnt_a), 32'd0);
        check("ovf_sticky", 32'(ovf_a), 32'd1);
        tick();
        check("q_a_drained", 32'(q_a.size()), 32'd0);

        // simultaneous at count=5
        reset_a();
        check("rst_clr_ovf", 32'(ovf_a), 32'd0);
        check("rst_clr_udf", 32'(udf_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            din_a = 8'h10 + 8'(i); wn_a = 1'b0;
            q_a.push_back(din_a);
            tick();
        end
        rn_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din_a = 8'h20 + 8'(i);
            q_a.push_back(din_a);
            tick();
            check("sim_count", 32'(cnt_a), 32'd5);
        end
        wn_a = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rn_a = 1'b1;
        tick();
        check("sim_empty", 32'(empty_a), 32'd1);
        check("sim_no_err", 32'({ovf_a, udf_a}), 32'd0);

        // full with both requests
        for (int i = 0; i < 16; i++) begin
            din_a = 8'h30 + 8'(i); wn_a = 1'b0;
            q_a.push_back(din_a);
            tick();
        end
        din_a = 8'hBB; rn_a = 1'b0;
        tick();
        check("fb_count", 32'(cnt_a), 32'd15);
        check("fb_ovf", 32'(ovf_a), 32'd1);
        check("fb_full", 32'(full_a), 32'd0);
        wn_a = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        rn_a = 1'b1;
        tick();
        check("fb_empty", 32'(empty_a), 32'd1);

        // empty with both requests
        reset_a();
        din_a = 8'hCC; wn_a = 1'b0; rn_a = 1'b0;
        q_a.push_back(8'hCC);
        tick();
        check("eb_count", 32'(cnt_a), 32'd1);
        check("eb_udf", 32'(udf_a), 32'd1);
`ifndef FIFO_SYNC_FWFT_EN
        check("eb_dv", 32'(dv_a), 32'd0);
`endif
        wn_a = 1'b1;
        tick();
        rn_a = 1'b1;
        check("eb_count0", 32'(cnt_a), 32'd0);
        tick();

`ifdef FIFO_SYNC_FWFT_EN
        reset_a();
        din_a = 8'h5A; wn_a = 1'b0;
        q_a.push_back(8'h5A);
        tick();
        wn_a = 1'b1;
        check("fwft_data", 32'(dout_a), 32'h5A);
        check("fwft_dv", 32'(dv_a), 32'd1);
        rn_a = 1'b0;
        tick();
        rn_a = 1'b1;
        check("fwft_empty", 32'(empty_a), 32'd1);
        check("fwft_dv0", 32'(dv_a), 32'd0);
`endif

        // wrap stream on DEPTH=8
        sent = 0; mcnt = 0; cyc = 0;
        while (recv_b < 20 && cyc < 1000) begin
            do_w = (sent < 20) && ($urandom_range(0, 2) != 0) && (mcnt < 8);
            do_r = (mcnt > 0) && ($urandom_range(0, 1) == 0);
            wn_b = !do_w; rn_b = !do_r;
            din_b = 8'(sent + 1);
            if (do_w) begin
                q_b.push_back(din_b);
                sent++;
            end
            mcnt = mcnt + int'(do_w) - int'(do_r);
            tick();
            cyc++;
        end
        wn_b = 1'b1; rn_b = 1'b1;
        tick();
        check("wrap_recv", 32'(recv_b), 32'd20);
        check("wrap_ovf", 32'(ovf_b), 32'd0);
        check("wrap_udf", 32'(udf_b), 32'd0);
        check("wrap_empty", 32'(empty_b), 32'd1);
        check("q_a_left", 32'(q_a.size()), 32'd0);
        check("q_b_left", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
